// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - packed-BCD adder/subtractor, one digit per clock, start/done handshake
// Optional input digit validation enabled by defining BCD_CHECK_EN.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic          load;
  logic          last;
  logic [IW-1:0] idx;
  logic          carry;
  logic          sub_r;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nx;
  logic [3:0]    b_digit;
  logic [4:0]    t;
  logic [3:0]    digit;
  logic          carry_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign last = (idx == LAST);

  // A start in the DONE cycle is accepted so results can stream back to back.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction adds the nines' complement of B with an initial carry of one.
  always_comb begin
    b_digit  = sub_r ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
    t        = {1'b0, a_sh[3:0]} + {1'b0, b_digit} + {4'd0, carry};
    carry_nx = (t > 5'd9);
    digit    = carry_nx ? (t[3:0] + 4'd6) : t[3:0];
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign acc_nx = digit;
    end else begin : g_many
      assign acc_nx = {digit, acc[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      idx   <= '0;
      carry <= sub;
      sub_r <= sub;
      a_sh  <= a;
      b_sh  <= b;
      acc   <= '0;
    end else if (busy) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      acc   <= acc_nx;
      carry <= carry_nx;
      if (last) begin
        sum  <= acc_nx;
        cout <= carry_nx;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic inv_acc;
  logic inv_nx;

  assign inv_nx = inv_acc | (a_sh[3:0] > 4'd9) | (b_sh[3:0] > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_acc <= 1'b0;
      invalid <= 1'b0;
    end else if (load) begin
      inv_acc <= 1'b0;
    end else if (busy) begin
      inv_acc <= inv_nx;
      if (last) invalid <= inv_nx;
    end
  end
`else
  assign invalid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - directed vector bench for bcd_serial_adder (DIGITS=4)
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        c;
  } vec_t;

  vec_t vecs[12];

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1};
    vecs[2]  = '{1'b0, 16'h0123, 16'h0789, 16'h0912, 1'b0};
    vecs[3]  = '{1'b1, 16'h0500, 16'h0123, 16'h0377, 1'b1};
    vecs[4]  = '{1'b1, 16'h0123, 16'h0500, 16'h9623, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 16'h5000, 16'h5000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b0};
    vecs[9]  = '{1'b0, 16'h4567, 16'h5433, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 16'h9999, 16'h9999, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0};

    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_invalid", {31'd0, invalid}, 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(n);
      check($sformatf("latency_%0d", i), n, 32'd4);
      check($sformatf("busy_in_done_%0d", i), {31'd0, busy}, 32'd0);
      check($sformatf("sum_%0d", i), {16'd0, sum}, {16'd0, vecs[i].sum});
      check($sformatf("cout_%0d", i), {31'd0, cout}, {31'd0, vecs[i].c});
      check($sformatf("invalid_%0d", i), {31'd0, invalid}, 32'd0);
      @(negedge clk);
      check($sformatf("done_pulse_%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("sum_hold_%0d", i), {16'd0, sum}, {16'd0, vecs[i].sum});
    end

    // start while busy is ignored
    issue(16'h0123, 16'h0789, 1'b0);
    a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignored_latency", n, 32'd3);
    check("ignored_sum", {16'd0, sum}, 32'h0912);
    check("ignored_cout", {31'd0, cout}, 32'd0);

    // start accepted in the done cycle
    issue(16'h0500, 16'h0123, 1'b1);
    wait_done(n);
    check("b2b_sum", {16'd0, sum}, 32'h0377);
    issue(16'h0005, 16'h0003, 1'b0);
    wait_done(n);
    check("b2b_latency", n, 32'd4);
    check("b2b_sum2", {16'd0, sum}, 32'h0008);
    check("b2b_cout2", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // reset in the middle of an add
    issue(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_sum", {16'd0, sum}, 32'd0);
    check("rst_mid_cout", {31'd0, cout}, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n++;
      @(negedge clk);
    end
    check("rst_mid_no_done", n, 32'd0);

    // non-BCD digit in A
    issue(16'h00A0, 16'h0001, 1'b0);
    wait_done(n);
    check("inv_latency", n, 32'd4);
`ifdef BCD_CHECK_EN
    check("invalid_flag", {31'd0, invalid}, 32'd1);
`else
    check("invalid_flag", {31'd0, invalid}, 32'd0);
`endif
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Multi-digit packed-BCD adder/subtractor, processed one decimal digit per clock, with a start/done handshake. Parametrised successor to the team's single-digit combinational decimal adder: generalised to `DIGITS` digits, adds subtraction by nines'-complement, carry-in and optional digit validation. Sits between the operand registers and the display/result path of the decimal arithmetic unit.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand, ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request operation; accepted only when `busy`=0.
- `sub`  in  1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a`  in  4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0]; sampled with `start`.
- `b`  in  4*DIGITS: operand B, same format.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse; `sum`/`cout`/`invalid` valid.
- `sum`  out  4*DIGITS: packed-BCD result.
- `cout`  out  1: add: decimal carry out; sub: 1 = no borrow, 0 = borrow.
- `invalid`  out  1: any input digit >9 (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → latch `a`, `b`, `sub`; digit index ←0; carry ← `sub`; clear `sum` shift register; → RUN.
- RUN: each cycle processes digit i: bi' = `sub` ? 9−bi : bi; t = ai + bi' + carry (5 bits); if t>9 then digit = t+6 (low 4 bits), carry=1, else digit = t, carry=0. Store digit i, i←i+1. After digit DIGITS−1 → DONE.
- DONE: `done`=1 one cycle; `sum`, `cout` (final carry), `invalid` updated; → IDLE, or directly → RUN if `start`=1 in this cycle.
- Subtraction: result = A + (10^DIGITS−1−B) + 1. If A<B, `cout`=0 and `sum` = ten's complement of |A−B| (e.g. 0123−0500 → 9623).
- `start` while `busy`=1: ignored, no effect on the operation in flight.
- `sum`, `cout`, `invalid` hold last result until the next `done`.
- Index counter width ⌈log2(DIGITS)⌉ (min 1); no wrap beyond DIGITS−1.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `invalid`=0, state IDLE.
- `start` sampled at edge k → `busy`=1 from edge k until edge k+DIGITS; `done`=1 during cycle after edge k+DIGITS; latency DIGITS+1 cycles from start sample to `done` deassert… precisely: `done` high for exactly one cycle, starting DIGITS edges after the sampling edge.
- `busy`=0 whenever `done`=1; `start` in the `done` cycle is accepted (back-to-back throughput: one result per DIGITS+1 cycles... i.e. one per DIGITS cycles' work plus the DONE cycle).
- `rst` mid-operation: next edge → IDLE, all outputs to reset values; no `done` for the aborted op.
- `rst` and `start` simultaneously: reset wins.

## Configuration
- `BCD_CHECK_EN` defined: every latched digit of A and B checked in RUN; `invalid` = OR over all digits >9, presented with `done`. Arithmetic still performed as specified.
- Not defined: no check logic; `invalid` tied 0. Non-BCD inputs produce deterministic but unspecified `sum`.

## Test plan
- Reset, then A=0005, B=0003, sub=0 → `done` after 4 digit cycles, `sum`=0008, `cout`=0; all outputs 0 before start.
- A=9999, B=0001, sub=0 → `sum`=0000, `cout`=1; A=0123, B=0789 → `sum`=0912, `cout`=0.
- sub=1: A=0500, B=0123 → `sum`=0377, `cout`=1; A=0123, B=0500 → `sum`=9623, `cout`=0.
- Pulse `start` with new operands while `busy`=1 → ignored, first result unchanged; `start` in `done` cycle → second result after DIGITS+1 cycles.
- Assert `rst` at digit 2 of an add → next cycle `busy`=0, `sum`=0000, no `done` pulse.
- With `BCD_CHECK_EN`: A=00A0, B=0001 → `invalid`=1 with `done`; without macro `invalid` stays 0.
